text_plane_writer: RTL and testbench

//  Producer side of the character/attribute text plane in SDRAM; the display

---
 rtl/text_plane_writer.sv | 159 +++++++++++++++
 tb/tb_text_plane_writer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_plane_writer.sv
// Producer side of the SDRAM text plane: writes charattr cells at a cursor and,
// on overflow past the last row, rotates first_row and blanks the recycled row.
module text_plane_writer #(
  parameter int          COLUMNS    = 80,
  parameter int          ROWS       = 51,
  parameter int          ROW_SIZE   = 80,
  parameter logic [31:0] CLEAR_WORD = 32'h0000_0020,
  parameter logic [3:0]  REG_FIRST  = 4'd2,
  parameter logic [3:0]  REG_CURSOR = 4'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [22:0] base_address,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [31:0] cmd_data,
  output logic        wr_request,
  output logic [22:0] wr_address,
  output logic [31:0] wr_data,
  input  logic        wr_done,
  output logic [3:0]  register_index,
  output logic [22:0] register_value,
  output logic        busy
);

  localparam int          PAGE_SIZE = ROWS * ROW_SIZE;
  localparam logic [22:0] PAGE      = 23'(PAGE_SIZE);
  localparam logic [22:0] ROW_STEP  = 23'(ROW_SIZE);
  localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
  localparam logic [6:0]  LAST_COL  = 7'(COLUMNS - 1);

  typedef enum logic [2:0] {IDLE, CELL_WR, CUR_REG, SCROLL_REG, CLR_WR} state_t;

  state_t      state, state_next;
  logic [5:0]  row;
  logic [6:0]  col;
  // Page-relative offsets, so reset values stay constant while base_address is live.
  logic [22:0] first_off;
  logic [22:0] row_off;
  logic [6:0]  clr_count;

  logic        accept, at_end, last_clear;
  logic [5:0]  set_row;
  logic [6:0]  set_col;
  logic [22:0] first_next;

  function automatic logic [22:0] page_wrap(input logic [22:0] v);
    return (v >= PAGE) ? v - PAGE : v;
  endfunction

  always_comb begin
    accept     = cmd_valid && cmd_ready;
    at_end     = (row == LAST_ROW) && (col == LAST_COL);
    last_clear = wr_request && wr_done && (clr_count == LAST_COL);
    set_row    = (cmd_data[12:7] > LAST_ROW) ? LAST_ROW : cmd_data[12:7];
    set_col    = (cmd_data[6:0] > LAST_COL) ? LAST_COL : cmd_data[6:0];
    first_next = page_wrap(first_off + ROW_STEP);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (accept) state_next = cmd_op ? CUR_REG : CELL_WR;
      CELL_WR:    if (!wr_request) state_next = at_end ? SCROLL_REG : CUR_REG;
      CUR_REG:    state_next = IDLE;
      SCROLL_REG: state_next = CLR_WR;
      CLR_WR:     if (last_clear) state_next = CUR_REG;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = (state == IDLE) && reset;
    busy           = (state != IDLE);
    register_index = 4'd0;
    register_value = 23'd0;
    case (state)
      CUR_REG: begin
        register_index = REG_CURSOR;
        register_value = {10'b0, row, col};
      end
      SCROLL_REG: begin
        register_index = REG_FIRST;
        register_value = base_address + first_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row        <= '0;
      col        <= '0;
      first_off  <= '0;
      row_off    <= '0;
      clr_count  <= '0;
      wr_request <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !cmd_op) begin
            wr_address <= base_address + row_off + {16'b0, col};
            wr_data    <= cmd_data;
            wr_request <= 1'b1;
          end else if (accept) begin
            row     <= set_row;
            col     <= set_col;
            // Constant multiplier: reduces to a shift/add network.
            row_off <= page_wrap(first_off + 23'(set_row) * ROW_STEP);
          end
        end
        CELL_WR: begin
          if (wr_request) begin
            if (wr_done) wr_request <= 1'b0;
          end else if (col == LAST_COL) begin
            col <= '0;
            if (row != LAST_ROW) begin
              row     <= row + 6'd1;
              row_off <= page_wrap(row_off + ROW_STEP);
            end
          end else begin
            col <= col + 7'd1;
          end
        end
        SCROLL_REG: begin
          // The bottom row now lands on the old first row, which is also what gets blanked.
          first_off  <= first_next;
          row_off    <= first_off;
          wr_address <= base_address + first_off;
          wr_data    <= CLEAR_WORD;
          wr_request <= 1'b1;
          clr_count  <= '0;
        end
        CLR_WR: begin
          if (wr_request && wr_done) begin
            if (clr_count == LAST_COL) begin
              wr_request <= 1'b0;
            end else begin
              clr_count  <= clr_count + 7'd1;
              wr_address <= wr_address + 23'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_plane_writer.sv
// Directed bench for text_plane_writer with a write/register scoreboard fed by a
// cursor/first_row reference model.
module tb_text_plane_writer;

  localparam logic [22:0] BASE = 23'h100000;

  typedef struct { logic [22:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [3:0] idx; logic [22:0] val; } reg_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [22:0] base_address = BASE;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [31:0] cmd_data = '0;
  logic        wr_request;
  logic [22:0] wr_address;
  logic [31:0] wr_data;
  logic        wr_done = 1'b0;
  logic [3:0]  register_index;
  logic [22:0] register_value;
  logic        busy;

  text_plane_writer dut (
    .clk(clk), .reset(reset), .base_address(base_address),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .wr_request(wr_request), .wr_address(wr_address), .wr_data(wr_data), .wr_done(wr_done),
    .register_index(register_index), .register_value(register_value), .busy(busy)
  );

  always #5 clk = ~clk;

  wr_t         exp_wr[$];
  reg_t        exp_reg[$];
  wr_t         got_wr;
  reg_t        got_reg;
  int          checks = 0;
  int          errors = 0;
  int          done_delay = 3;
  int          done_cnt = 0;
  int          m_row = 0, m_col = 0, m_first = 0;
  logic [22:0] last_first = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // SDRAM controller stand-in: acknowledges after done_delay waiting cycles.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        wr_done = 1'b0; done_cnt = 0;
      end else if (wr_request && !wr_done) begin
        if (done_cnt >= done_delay) begin wr_done = 1'b1; done_cnt = 0; end
        else done_cnt++;
      end else begin
        wr_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (wr_request && wr_done) begin
        check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          got_wr = exp_wr.pop_front();
          check("wr_addr", 32'(wr_address), 32'(got_wr.addr));
          check("wr_data", wr_data, got_wr.data);
        end
      end
      if (register_index != 4'd0) begin
        check("reg_expected", 32'(exp_reg.size() != 0), 32'd1);
        if (exp_reg.size() != 0) begin
          got_reg = exp_reg.pop_front();
          check("reg_index", 32'(register_index), 32'(got_reg.idx));
          check("reg_value", 32'(register_value), 32'(got_reg.val));
        end
        if (register_index == 4'd2) last_first = register_value;
      end
    end
  end

  function automatic logic [22:0] cell_addr();
    return BASE + 23'((m_first + m_row * 80) % 4080 + m_col);
  endfunction

  task automatic push_wr(input logic [22:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_reg(input logic [3:0] i, input logic [22:0] v);
    reg_t r;
    r.idx = i; r.val = v;
    exp_reg.push_back(r);
  endtask

  task automatic model_put(input logic [31:0] d);
    int old;
    push_wr(cell_addr(), d);
    if (m_col == 79) begin
      m_col = 0;
      if (m_row == 50) begin
        old = m_first;
        m_first = (m_first + 80) % 4080;
        push_reg(4'd2, BASE + 23'(m_first));
        for (int i = 0; i < 80; i++) push_wr(BASE + 23'(old + i), 32'h0000_0020);
      end else begin
        m_row++;
      end
    end else begin
      m_col++;
    end
    push_reg(4'd3, 23'(m_row * 128 + m_col));
  endtask

  task automatic model_set(input int r, input int c);
    m_row = (r > 50) ? 50 : r;
    m_col = (c > 79) ? 79 : c;
    push_reg(4'd3, 23'(m_row * 128 + m_col));
  endtask

  task automatic send(input logic op, input logic [31:0] d);
    bit ok = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin @(posedge clk); #1; ok = 1'b1; end
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    check("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic put(input logic [31:0] d);
    model_put(d); send(1'b0, d); wait_idle();
  endtask

  task automatic set_cur(input int r, input int c);
    model_set(r, c); send(1'b1, 32'((r << 7) | c)); wait_idle();
  endtask

  initial begin
    bit          seen;
    logic [22:0] hold_addr;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_wr_request", 32'(wr_request), 32'd0);
    check("rst_wr_address", 32'(wr_address), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_reg_index", 32'(register_index), 32'd0);
    check("rst_reg_value", 32'(register_value), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    // First PUT with latency probes: request 1 cycle after accept, strobe 2 after wr_done
    model_put(32'h1F00_0041);
    send(1'b0, 32'h1F00_0041);
    @(negedge clk);
    check("put_req_latency", 32'(wr_request), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (wr_done) seen = 1'b1; else @(negedge clk);
    end
    check("wr_done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("req_drop_after_done", 32'(wr_request), 32'd0);
    check("no_strobe_yet", 32'(register_index), 32'd0);
    @(negedge clk);
    check("cursor_strobe_latency", 32'(register_index), 32'd3);
    wait_idle();

    // Row wrap and clamping
    set_cur(10, 79);
    put(32'h0700_0042);
    set_cur(63, 127);

    // Scroll from (50,79), then 50 more to return first_row to base
    done_delay = 0;
    put(32'h0E00_0058);
    check("first_after_scroll", 32'(last_first), 32'(BASE + 23'd80));
    for (int s = 0; s < 50; s++) begin
      set_cur(50, 79);
      put(32'h0A00_0030 + 32'(s));
    end
    check("first_after_51_scrolls", 32'(last_first), 32'(BASE));

    // Held-off wr_done with a command waiting behind it
    done_delay = 20;
    hold_addr = cell_addr();
    model_put(32'h1234_5678);
    model_set(3, 4);
    send(1'b0, 32'h1234_5678);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_data = 32'((3 << 7) | 4);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("hold_req", 32'(wr_request), 32'd1);
      check("hold_addr", 32'(wr_address), 32'(hold_addr));
      check("hold_data", wr_data, 32'h1234_5678);
      check("hold_ready", 32'(cmd_ready), 32'd0);
    end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (cmd_ready) begin @(posedge clk); #1; seen = 1'b1; end
    end
    cmd_valid = 1'b0;
    check("pending_cmd_accepted", 32'(seen), 32'd1);
    wait_idle();
    done_delay = 0;

    // Reset in the middle of the row clear
    set_cur(50, 79);
    model_put(32'h0000_0777);
    send(1'b0, 32'h0000_0777);
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (exp_wr.size() <= 40) seen = 1'b1;
    end
    check("reached_mid_clear", 32'(seen), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_wr_request", 32'(wr_request), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("midrst_reg_index", 32'(register_index), 32'd0);
    exp_wr.delete();
    exp_reg.delete();
    m_row = 0; m_col = 0; m_first = 0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", 32'(cmd_ready), 32'd1);
    put(32'h1F00_0041);

    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("reg_queue_drained", 32'(exp_reg.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
